// File: rtl/stack_reader.sv
// stack_reader: drains a RAM-backed LIFO stack onto a valid/ready stream.
// On start it pops every entry, top first, and presents each one downstream.
// The final entry is flagged with out_last.
// The stack's one-cycle registered read latency is absorbed by alternating
// between POP (strobe + capture) and PRESENT (handshake) states.
module stack_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  stk_pop,
  input  logic [DATA_WIDTH-1:0] stk_data,
  input  logic                  stk_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_reg;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  start_accept;
  logic                  handshake;

  // A start only counts when sampled in IDLE; elsewhere it is ignored.
  assign start_accept = (state_reg == IDLE) && start;
  assign handshake    = (state_reg == PRESENT) && out_ready;

  // State register; reset aborts any drain in progress immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. The stack pointer is stable throughout PRESENT, so
  // stk_empty there tells whether the presented entry was the last one.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = stk_empty ? DONE : POP;
        end
      end
      POP: begin
        state_next = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          state_next = stk_empty ? DONE : POP;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the top-of-stack word on the POP cycle; the registered read data
  // is already valid there because the pointer has been stable for a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= '0;
    end else if (state_reg == POP) begin
      data_reg <= stk_data;
    end
  end

  // Emitted-entry counter: cleared by an accepted start, bumped per handshake,
  // and otherwise held so the result of the last drain stays visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (start_accept) begin
      count_reg <= '0;
    end else if (handshake) begin
      count_reg <= count_reg + COUNT_ONE;
    end
  end

  // Moore-style outputs decoded from the state register. stk_pop is also
  // gated by stk_empty so an empty stack can never be popped.
  always_comb begin
    busy      = (state_reg != IDLE);
    done      = (state_reg == DONE);
    stk_pop   = (state_reg == POP) && !stk_empty;
    out_valid = (state_reg == PRESENT);
    out_last  = (state_reg == PRESENT) && stk_empty;
    out_data  = data_reg;
    count     = count_reg;
  end

endmodule

// File: tb/tb_stack_reader.sv
// tb_stack_reader: scoreboard bench for stack_reader with a behavioural
// LIFO stack (registered read data, pointer untouched by DUT reset).
module tb_stack_reader;

  localparam int AW = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          stk_pop;
  logic [DW-1:0] stk_data;
  logic          stk_empty;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;

  // Stack model
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   sp = '0;

  int   cyc = 0;
  int   start_cyc = 0;
  int   pop_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   done_cnt_q[$];
  int   done_dly_q[$];

  stack_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .stk_pop  (stk_pop),
    .stk_data (stk_data),
    .stk_empty(stk_empty),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign stk_empty = (sp == '0);

  always @(posedge clk) begin
    if (push) begin
      mem[sp[AW-1:0]] <= push_data;
      sp <= sp + 1'b1;
    end else if (stk_pop) begin
      sp <= sp - 1'b1;
    end
    stk_data <= mem[sp[AW-1:0] - 4'd1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and every done pulse.
  always @(negedge clk) begin
    if (reset_n) begin
      if (stk_pop) begin
        pop_cnt++;
        chk("pop_while_empty", {63'd0, stk_empty}, 64'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {31'd0, out_data, out_last}, 64'd0 - 64'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("beat data=%0h last=%0b (expected %0h/%0b)", out_data, out_last, e.data, e.last);
          chk("beat", {31'd0, out_data, out_last}, {31'd0, e.data, e.last});
        end
      end
      if (done) begin
        if (done_cnt_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          int c;
          int d;
          c = done_cnt_q.pop_front();
          d = done_dly_q.pop_front();
          $display("done count=%0d after %0d cycles", count, cyc - start_cyc);
          chk("done_count", 64'(count), 64'(c));
          if (d >= 0) chk("done_latency", 64'(cyc - start_cyc), 64'(d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [DW-1:0] v);
    push_data = v;
    push = 1'b1;
    tick();
    push = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_beat(input logic [DW-1:0] v, input logic l);
    exp_t e;
    e.data = v;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic expect_done(input int c, input int d);
    done_cnt_q.push_back(c);
    done_dly_q.push_back(d);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (!busy && exp_q.size() == 0 && done_cnt_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_complete", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_valid(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("valid_seen", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {22'd0, busy, done, stk_pop, out_valid, out_last, count, out_data}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Three entries, consumer always ready
    push_val(32'h0A); push_val(32'h0B); push_val(32'h0C);
    tick();
    expect_beat(32'h0C, 1'b0); expect_beat(32'h0B, 1'b0); expect_beat(32'h0A, 1'b1);
    expect_done(3, 7);
    out_ready = 1'b1;
    pulse_start();
    wait_idle(40);
    chk("empty_after_drain", {63'd0, stk_empty}, 64'd1);
    chk("count_held", 64'(count), 64'd3);

    // Empty stack
    pop_cnt = 0;
    expect_done(0, 1);
    pulse_start();
    wait_idle(10);
    chk("empty_no_pop", 64'(pop_cnt), 64'd0);

    // Backpressure: 0x11 on top, held for 5 cycles
    push_val(32'h22); push_val(32'h11);
    tick();
    out_ready = 1'b0;
    pop_cnt = 0;
    expect_beat(32'h11, 1'b0); expect_beat(32'h22, 1'b1);
    expect_done(2, -1);
    pulse_start();
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_beat", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h11});
    end
    chk("hold_single_pop", 64'(pop_cnt), 64'd1);
    out_ready = 1'b1;
    wait_idle(20);
    chk("hold_total_pops", 64'(pop_cnt), 64'd2);

    // Nearly full stack: 1..15
    for (int v = 1; v <= 15; v++) push_val(32'(v));
    tick();
    for (int v = 15; v >= 1; v--) expect_beat(32'(v), v == 1);
    expect_done(15, 31);
    pulse_start();
    wait_idle(100);
    chk("full_count", 64'(count), 64'd15);

    // Reset during PRESENT of the second entry
    push_val(32'h31); push_val(32'h32); push_val(32'h33);
    tick();
    out_ready = 1'b0;
    expect_beat(32'h33, 1'b0);
    pulse_start();
    wait_valid(10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("second_presented", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h32});
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {22'd0, busy, done, stk_pop, out_valid, out_last, count, out_data}, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", {63'd0, busy}, 64'd0);
    expect_beat(32'h31, 1'b1);
    expect_done(1, 3);
    out_ready = 1'b1;
    pulse_start();
    wait_idle(20);

    // Start held through busy and the DONE cycle
    push_val(32'h41); push_val(32'h42); push_val(32'h43);
    tick();
    pop_cnt = 0;
    expect_beat(32'h43, 1'b0); expect_beat(32'h42, 1'b0); expect_beat(32'h41, 1'b1);
    expect_done(3, 7);
    start = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin
        tick();
        break;
      end
    end
    start = 1'b0;
    repeat (4) tick();
    chk("restart_idle", {63'd0, busy}, 64'd0);
    chk("restart_pops", 64'(pop_cnt), 64'd3);
    chk("restart_count", 64'(count), 64'd3);
    chk("restart_queue_empty", 64'(exp_q.size() + done_cnt_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
